// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg: shared types and default parameter values for the
// sync_debounce block.
//   db_state_t  - per-channel debounce FSM state (2-bit enum)
//   DEF_*       - default parameter constants used by the top and channel
package sync_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } db_state_t;

    localparam int DEF_CHANNELS        = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 100000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one button/switch channel -- synchroniser chain, four-state
// debounce FSM with stability counter, optional auto-repeat timer.
// Optional feature macro: SYNC_DEBOUNCE_REPEAT_EN (auto-repeat press pulses).
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   din    - raw asynchronous input
//   level  - debounced state
//   press  - one-cycle pulse on accepted press (and repeats when enabled)
//   rel    - one-cycle pulse on accepted release ("release" is a reserved word)
module debounce_channel
    import sync_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef SYNC_DEBOUNCE_REPEAT_EN
   ,parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // Counter value on the edge before acceptance; compare against this
    // instead of cnt+1 so the counter never needs a wider adder result.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    db_state_t              st;
    logic [CW-1:0]          cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], din};
    end

    assign s = sync[SYNC_STAGES-1];

`ifdef SYNC_DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rtmr;    // cycles spent holding in HIGH since last press
    logic          rfirst;  // next repeat uses the initial delay
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= ST_LOW;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
`ifdef SYNC_DEBOUNCE_REPEAT_EN
            rtmr   <= '0;
            rfirst <= 1'b0;
`endif
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            case (st)
                ST_LOW: if (s) begin
                    // With a one-cycle qualification the first sample accepts.
                    if (DEBOUNCE_CYCLES == 1) begin
                        st    <= ST_HIGH;
                        level <= 1'b1;
                        press <= 1'b1;
`ifdef SYNC_DEBOUNCE_REPEAT_EN
                        rtmr   <= '0;
                        rfirst <= 1'b1;
`endif
                    end else begin
                        st  <= ST_WAIT_HIGH;
                        cnt <= CW'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!s) begin
                        st  <= ST_LOW;
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        st    <= ST_HIGH;
                        cnt   <= '0;
                        level <= 1'b1;
                        press <= 1'b1;
`ifdef SYNC_DEBOUNCE_REPEAT_EN
                        rtmr   <= '0;
                        rfirst <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (!s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            st    <= ST_LOW;
                            level <= 1'b0;
                            rel   <= 1'b1;
`ifdef SYNC_DEBOUNCE_REPEAT_EN
                            rtmr   <= '0;
                            rfirst <= 1'b0;
`endif
                        end else begin
                            // Repeat timer holds its value while in WAIT_LOW.
                            st  <= ST_WAIT_LOW;
                            cnt <= CW'(1);
                        end
                    end
`ifdef SYNC_DEBOUNCE_REPEAT_EN
                    else if (rtmr == (rfirst ? RD_LAST : RP_LAST)) begin
                        press  <= 1'b1;
                        rtmr   <= '0;
                        rfirst <= 1'b0;
                    end else begin
                        rtmr <= rtmr + RW'(1);
                    end
`endif
                end
                ST_WAIT_LOW: begin
                    if (s) begin
                        st  <= ST_HIGH;
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        st    <= ST_LOW;
                        cnt   <= '0;
                        level <= 1'b0;
                        rel   <= 1'b1;
`ifdef SYNC_DEBOUNCE_REPEAT_EN
                        rtmr   <= '0;
                        rfirst <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    st  <= ST_LOW;
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: CHANNELS independent synchronise-and-debounce channels with
// one-cycle press/release pulses.
// Optional feature macro: SYNC_DEBOUNCE_REPEAT_EN (auto-repeat on held press;
// REPEAT_DELAY / REPEAT_PERIOD only matter when it is defined).
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   din    - [CHANNELS] raw asynchronous inputs
//   level  - [CHANNELS] debounced state
//   press  - [CHANNELS] one-cycle press pulses
//   rel    - [CHANNELS] one-cycle release pulses ("release" is a reserved word)
module sync_debounce
    import sync_debounce_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] rel
);

    if (CHANNELS < 1 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("sync_debounce: illegal parameter value");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef SYNC_DEBOUNCE_REPEAT_EN
           ,.REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (din[i]),
            .level (level[i]),
            .press (press[i]),
            .rel   (rel[i])
        );
    end

endmodule
